heading_update_ctrl: RTL and testbench

HEADING_UPDATE_CTRL -- requirements
Module: heading_update_ctrl

---
 rtl/heading_update_ctrl.sv | 173 +++++++++++++++++
 tb/tb_heading_update_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heading_update_ctrl.sv
// Averages NUM_SAMPLES pinger fixes per axis and issues (pinger average - AUV position)
// as a heading vector over valid/ready, with an inter-sample timeout and a post-issue holdoff.
module heading_update_ctrl #(
  parameter int NUM_SAMPLES    = 4,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pinger_valid,
  output logic       pinger_ready,
  input  logic [7:0] pinger_x,
  input  logic [7:0] pinger_y,
  input  logic [7:0] pinger_z,
  input  logic [7:0] auv_x,
  input  logic [7:0] auv_y,
  input  logic [7:0] auv_z,
  output logic       heading_valid,
  input  logic       heading_ready,
  output logic [8:0] heading_dx,
  output logic [8:0] heading_dy,
  output logic [8:0] heading_dz,
  output logic       busy,
  output logic       stale
);

  localparam int         SHIFT      = $clog2(NUM_SAMPLES);
  localparam logic [3:0] COUNT_LAST = 4'(NUM_SAMPLES);
  localparam logic [7:0] GAP_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCUM   = 3'd1,
    S_CALC    = 3'd2,
    S_ISSUE   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0][10:0]  sum_q, sum_d;
  logic [3:0]        count_q, count_d;
  logic [7:0]        gap_q, gap_d;
  logic [7:0]        hold_q, hold_d;
  logic [2:0][8:0]   heading_q, heading_d;
  logic              pinger_ready_q, pinger_ready_d;
  logic              heading_valid_q, heading_valid_d;
  logic              busy_q, busy_d;
  logic              stale_q, stale_d;

  logic [2:0][7:0]   pinger_pos;
  logic [2:0][7:0]   auv_pos;
  logic [2:0][8:0]   diff;
  logic              accept;
  logic              timeout;

  assign pinger_pos = {pinger_z, pinger_y, pinger_x};
  assign auv_pos    = {auv_z, auv_y, auv_x};
  assign accept     = pinger_valid & pinger_ready_q;

  // Both operands are zero-extended to 9 bits, so the difference spans -255..+255 exactly.
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic [7:0] avg;
    assign avg      = 8'(sum_q[gi] >> SHIFT);
    assign diff[gi] = {1'b0, avg} - {1'b0, auv_pos[gi]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      sum_q           <= '0;
      count_q         <= '0;
      gap_q           <= '0;
      hold_q          <= '0;
      heading_q       <= '0;
      pinger_ready_q  <= 1'b0;
      heading_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      stale_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      sum_q           <= sum_d;
      count_q         <= count_d;
      gap_q           <= gap_d;
      hold_q          <= hold_d;
      heading_q       <= heading_d;
      pinger_ready_q  <= pinger_ready_d;
      heading_valid_q <= heading_valid_d;
      busy_q          <= busy_d;
      stale_q         <= stale_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    count_d   = count_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    heading_d = heading_q;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int i = 0; i < 3; i++) sum_d[i] = {3'b000, pinger_pos[i]};
          count_d = 4'd1;
          gap_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Dropping enable abandons the batch silently; only a timeout reports stale.
        if (!enable) begin
          sum_d   = '0;
          count_d = '0;
          gap_d   = '0;
          state_d = S_IDLE;
        end else if (accept) begin
          for (int i = 0; i < 3; i++) sum_d[i] = sum_q[i] + {3'b000, pinger_pos[i]};
          count_d = count_q + 4'd1;
          gap_d   = '0;
          if (count_q + 4'd1 == COUNT_LAST) state_d = S_CALC;
        end else if (gap_q == GAP_LAST) begin
          sum_d   = '0;
          count_d = '0;
          gap_d   = '0;
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_CALC: begin
        heading_d = diff;
        sum_d     = '0;
        count_d   = '0;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (heading_ready) begin
          hold_d  = '0;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pinger_ready_d  = enable && (state_d == S_IDLE || state_d == S_ACCUM);
    heading_valid_d = (state_d == S_ISSUE);
    busy_d          = (state_d != S_IDLE);
    stale_d         = timeout;
  end

  assign pinger_ready  = pinger_ready_q;
  assign heading_valid = heading_valid_q;
  assign heading_dx    = heading_q[0];
  assign heading_dy    = heading_q[1];
  assign heading_dz    = heading_q[2];
  assign busy          = busy_q;
  assign stale         = stale_q;

endmodule

// File: tb/tb_heading_update_ctrl.sv
// Directed and randomized checks of heading_update_ctrl against an averaging model
// (batch sum / 4 minus AUV position) with handshake, timeout, holdoff and reset scenarios.
module tb_heading_update_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pinger_valid;
  logic       pinger_ready;
  logic [7:0] pinger_x, pinger_y, pinger_z;
  logic [7:0] auv_x, auv_y, auv_z;
  logic       heading_valid;
  logic       heading_ready;
  logic [8:0] heading_dx, heading_dy, heading_dz;
  logic       busy;
  logic       stale;

  int tests_run = 0;
  int failed    = 0;

  logic [7:0] sx [4];
  logic [7:0] sy [4];
  logic [7:0] sz [4];

  heading_update_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pinger_valid (pinger_valid),
    .pinger_ready (pinger_ready),
    .pinger_x     (pinger_x),
    .pinger_y     (pinger_y),
    .pinger_z     (pinger_z),
    .auv_x        (auv_x),
    .auv_y        (auv_y),
    .auv_z        (auv_z),
    .heading_valid(heading_valid),
    .heading_ready(heading_ready),
    .heading_dx   (heading_dx),
    .heading_dy   (heading_dy),
    .heading_dz   (heading_dz),
    .busy         (busy),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_const(input logic [7:0] v);
    for (int i = 0; i < 4; i++) begin
      sx[i] = v; sy[i] = v; sz[i] = v;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 4; i++) begin
      sx[i] = 8'($urandom_range(0, 255));
      sy[i] = 8'($urandom_range(0, 255));
      sz[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Present one sample and wait until it is taken.
  task automatic feed(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    pinger_valid = 1'b1;
    pinger_x = x; pinger_y = y; pinger_z = z;
    for (int n = 0; n < 100 && pinger_ready !== 1'b1; n++) step();
    chk("feed_ready", 32'(pinger_ready), 32'd1);
    step();
    $display("[TB] sample accepted x=%0d y=%0d z=%0d", x, y, z);
  endtask

  task automatic expect_heading(input logic [8:0] ex, input logic [8:0] ey,
                                input logic [8:0] ez, input int rdelay);
    chk("calc_valid_low", 32'(heading_valid), 32'd0);
    chk("calc_ready_low", 32'(pinger_ready), 32'd0);
    step();
    chk("issue_valid", 32'(heading_valid), 32'd1);
    chk("issue_dx", 32'(heading_dx), 32'(ex));
    chk("issue_dy", 32'(heading_dy), 32'(ey));
    chk("issue_dz", 32'(heading_dz), 32'(ez));
    chk("issue_ready_low", 32'(pinger_ready), 32'd0);
    for (int d = 0; d < rdelay; d++) begin
      heading_ready = 1'b0;
      pinger_valid  = 1'($urandom_range(0, 1));
      pinger_x = 8'($urandom_range(0, 255));
      auv_x    = 8'($urandom_range(0, 255));
      auv_y    = 8'($urandom_range(0, 255));
      auv_z    = 8'($urandom_range(0, 255));
      step();
      chk("wait_valid", 32'(heading_valid), 32'd1);
      chk("wait_dx", 32'(heading_dx), 32'(ex));
      chk("wait_dy", 32'(heading_dy), 32'(ey));
      chk("wait_dz", 32'(heading_dz), 32'(ez));
      chk("wait_ready_low", 32'(pinger_ready), 32'd0);
    end
    heading_ready = 1'b1;
    step();
    heading_ready = 1'b0;
    chk("hs_valid_fall", 32'(heading_valid), 32'd0);
    chk("hs_dx_held", 32'(heading_dx), 32'(ex));
    chk("hs_busy", 32'(busy), 32'd1);
    $display("[TB] heading issued dx=%h dy=%h dz=%h after %0d wait cycles", ex, ey, ez, rdelay);
  endtask

  // Holdoff must block 16 cycles of offered garbage samples, then reopen.
  task automatic check_holdoff();
    for (int i = 0; i < 16; i++) begin
      pinger_valid = 1'b1;
      pinger_x = 8'($urandom_range(0, 255));
      pinger_y = 8'($urandom_range(0, 255));
      pinger_z = 8'($urandom_range(0, 255));
      chk("holdoff_ready_low", 32'(pinger_ready), 32'd0);
      chk("holdoff_busy", 32'(busy), 32'd1);
      step();
    end
    chk("holdoff_end_ready", 32'(pinger_ready), 32'd1);
    chk("holdoff_end_busy", 32'(busy), 32'd0);
    pinger_valid = 1'b0;
    $display("[TB] holdoff window checked");
  endtask

  task automatic run_batch(input logic [7:0] ax, input logic [7:0] ay, input logic [7:0] az,
                           input int gapmax, input int rdelay);
    int tx, ty, tz, g;
    tx = 0; ty = 0; tz = 0;
    auv_x = ax; auv_y = ay; auv_z = az;
    for (int i = 0; i < 4; i++) begin
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      pinger_valid = 1'b0;
      repeat (g) step();
      feed(sx[i], sy[i], sz[i]);
      tx += int'(sx[i]); ty += int'(sy[i]); tz += int'(sz[i]);
    end
    pinger_valid = 1'b0;
    expect_heading(9'(tx / 4 - int'(ax)), 9'(ty / 4 - int'(ay)), 9'(tz / 4 - int'(az)), rdelay);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pready"}, 32'(pinger_ready), 32'd0);
    chk({tag, "_hvalid"}, 32'(heading_valid), 32'd0);
    chk({tag, "_dx"}, 32'(heading_dx), 32'd0);
    chk({tag, "_dy"}, 32'(heading_dy), 32'd0);
    chk({tag, "_dz"}, 32'(heading_dz), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stale"}, 32'(stale), 32'd0);
  endtask

  initial begin
    int pulses, first;
    logic busy_mid;

    rst = 1'b1; enable = 1'b1; pinger_valid = 1'b0; heading_ready = 1'b0;
    pinger_x = '0; pinger_y = '0; pinger_z = '0;
    auv_x = '0; auv_y = '0; auv_z = '0;
    repeat (3) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    chk("release_no_edge_ready", 32'(pinger_ready), 32'd0);
    step();
    chk("release_ready", 32'(pinger_ready), 32'd1);
    enable = 1'b0;
    step();
    chk("idle_disable_ready", 32'(pinger_ready), 32'd0);
    enable = 1'b1;
    step();
    chk("idle_enable_ready", 32'(pinger_ready), 32'd1);
    $display("[TB] reset and enable tracking checked");

    // Reference example: x=10,12,14,16 y=z=100, auv=(20,50,200).
    for (int i = 0; i < 4; i++) begin
      sx[i] = 8'(10 + 2 * i); sy[i] = 8'd100; sz[i] = 8'd100;
    end
    run_batch(8'd20, 8'd50, 8'd200, 0, 0);
    chk("example_dx", 32'(heading_dx), 32'h1F9);
    chk("example_dy", 32'(heading_dy), 32'd50);
    chk("example_dz", 32'(heading_dz), 32'h19C);
    check_holdoff();

    // Downstream stalls for 5 cycles.
    set_rand();
    run_batch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 5);
    check_holdoff();

    // Extremes of the difference range.
    set_const(8'd255);
    run_batch(8'd0, 8'd0, 8'd0, 0, 1);
    chk("max_dx", 32'(heading_dx), 32'h0FF);
    check_holdoff();
    set_const(8'd0);
    run_batch(8'd255, 8'd255, 8'd255, 1, 0);
    chk("min_dz", 32'(heading_dz), 32'h101);
    check_holdoff();

    // Two samples then silence: batch goes stale exactly once.
    set_const(8'd200);
    feed(sx[0], sy[0], sz[0]);
    feed(sx[1], sy[1], sz[1]);
    pinger_valid = 1'b0;
    pulses = 0; first = -1; busy_mid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 100) busy_mid = busy;
      if (stale === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("timeout_busy_mid", 32'(busy_mid), 32'd1);
    chk("stale_pulses", 32'(pulses), 32'd1);
    chk("stale_timing", 32'(first >= 254 && first <= 256), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    $display("[TB] stale pulse count=%0d at cycle %0d", pulses, first);
    set_rand();
    run_batch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2, 2);
    check_holdoff();

    // Enable dropped mid-batch: abandoned silently.
    set_const(8'd250);
    feed(sx[0], sy[0], sz[0]);
    feed(sx[1], sy[1], sz[1]);
    pinger_valid = 1'b0;
    enable = 1'b0;
    step();
    chk("disable_busy", 32'(busy), 32'd0);
    chk("disable_stale", 32'(stale), 32'd0);
    chk("disable_ready", 32'(pinger_ready), 32'd0);
    step();
    chk("disable_stale2", 32'(stale), 32'd0);
    enable = 1'b1;
    $display("[TB] enable drop in accumulation checked");
    set_rand();
    run_batch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
    check_holdoff();

    // Reset with three samples accumulated.
    set_const(8'd240);
    for (int i = 0; i < 3; i++) feed(sx[i], sy[i], sz[i]);
    pinger_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_accum");
    step();
    rst = 1'b0;
    $display("[TB] reset during accumulation");
    set_rand();
    run_batch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
    check_holdoff();

    // Reset with a heading pending.
    set_rand();
    auv_x = 8'd1; auv_y = 8'd2; auv_z = 8'd3;
    for (int i = 0; i < 4; i++) feed(sx[i], sy[i], sz[i]);
    pinger_valid = 1'b0;
    step();
    step();
    chk("pending_valid", 32'(heading_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_issue");
    step();
    rst = 1'b0;
    $display("[TB] reset during issue");
    set_rand();
    run_batch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1);
    check_holdoff();

    // Randomized batches with gaps and downstream stalls.
    for (int b = 0; b < 20; b++) begin
      set_rand();
      run_batch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                3, int'($urandom_range(0, 4)));
      check_holdoff();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
